// File: rtl/vip_pkg.sv
// Shared constants and helpers for the VIP colour-space stages.
// Coefficients are full-range BT.601 in Q8.
package vip_pkg;

    localparam int VIP_CSC_LAT = 4;
    localparam logic [7:0] CHROMA_OFS = 8'd128;

    localparam logic signed [17:0] COEF_CR_R = 18'sd359;
    localparam logic signed [17:0] COEF_CB_G = 18'sd88;
    localparam logic signed [17:0] COEF_CR_G = 18'sd183;
    localparam logic signed [17:0] COEF_CB_B = 18'sd454;

    // Saturate a signed Q8 sum into an 8-bit unsigned channel.
    function automatic logic [7:0] clamp_q8(input logic signed [19:0] sum);
        logic [7:0] res;
        if (sum[19]) begin
            res = 8'd0;
        end else if (sum[18:16] != 3'd0) begin
            res = 8'd255;
        end else begin
            res = sum[15:8];
        end
        return res;
    endfunction

    // Sign-extend an 18-bit product to the 20-bit accumulator width.
    function automatic logic signed [19:0] ext20(input logic signed [17:0] p);
        return $signed({{2{p[17]}}, p});
    endfunction

endpackage

// File: rtl/vip_sync_delay.sv
// Resettable shift register that delays VIP frame/line/enable strobes
// so they stay in lockstep with a fixed-latency pixel pipeline.
module vip_sync_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_r [DEPTH];

    // Shift the strobe bundle one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/vip_ycbcr444_rgb888.sv
// Four-stage YCbCr444 -> RGB888 converter; syncs are delayed alongside the
// data and RGB is blanked whenever the delayed line-valid is low.
module vip_ycbcr444_rgb888
    import vip_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_img_vsync,
    input  logic       per_img_href,
    input  logic       data_en_i,
    input  logic [7:0] per_img_Y,
    input  logic [7:0] per_img_Cb,
    input  logic [7:0] per_img_Cr,
    output logic       post_img_vsync,
    output logic       post_img_href,
    output logic       data_en_o,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);

    localparam logic signed [19:0] RND = ROUND_EN ? 20'sd128 : 20'sd0;

    logic [7:0]         y_r;
    logic signed [8:0]  cb_r;
    logic signed [8:0]  cr_r;
    logic signed [17:0] cb_ext_s;
    logic signed [17:0] cr_ext_s;
    logic signed [19:0] y_sh_r;
    logic signed [17:0] p_cr_r_r;
    logic signed [17:0] p_cb_g_r;
    logic signed [17:0] p_cr_g_r;
    logic signed [17:0] p_cb_b_r;
    logic signed [19:0] sum_r_r;
    logic signed [19:0] sum_g_r;
    logic signed [19:0] sum_b_r;
    logic [7:0]         red_r;
    logic [7:0]         green_r;
    logic [7:0]         blue_r;
    logic [2:0]         sync_s;

    assign cb_ext_s = $signed({{9{cb_r[8]}}, cb_r});
    assign cr_ext_s = $signed({{9{cr_r[8]}}, cr_r});

    // Stage 1: remove the chroma offset, keep luma aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r  <= 8'd0;
            cb_r <= 9'sd0;
            cr_r <= 9'sd0;
        end else begin
            y_r  <= per_img_Y;
            cb_r <= $signed({1'b0, per_img_Cb}) - $signed({1'b0, CHROMA_OFS});
            cr_r <= $signed({1'b0, per_img_Cr}) - $signed({1'b0, CHROMA_OFS});
        end
    end

    // Stage 2: Q8 products and luma scaled into the same Q8 domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_sh_r   <= 20'sd0;
            p_cr_r_r <= 18'sd0;
            p_cb_g_r <= 18'sd0;
            p_cr_g_r <= 18'sd0;
            p_cb_b_r <= 18'sd0;
        end else begin
            y_sh_r   <= $signed({4'b0000, y_r, 8'h00});
            p_cr_r_r <= cr_ext_s * COEF_CR_R;
            p_cb_g_r <= cb_ext_s * COEF_CB_G;
            p_cr_g_r <= cr_ext_s * COEF_CR_G;
            p_cb_b_r <= cb_ext_s * COEF_CB_B;
        end
    end

    // Stage 3: full-width signed sums, rounding bias folded in here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r_r <= 20'sd0;
            sum_g_r <= 20'sd0;
            sum_b_r <= 20'sd0;
        end else begin
            sum_r_r <= y_sh_r + ext20(p_cr_r_r) + RND;
            sum_g_r <= y_sh_r - ext20(p_cb_g_r) - ext20(p_cr_g_r) + RND;
            sum_b_r <= y_sh_r + ext20(p_cb_b_r) + RND;
        end
    end

    // Stage 4: saturate to 8-bit channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_r   <= 8'd0;
            green_r <= 8'd0;
            blue_r  <= 8'd0;
        end else begin
            red_r   <= clamp_q8(sum_r_r);
            green_r <= clamp_q8(sum_g_r);
            blue_r  <= clamp_q8(sum_b_r);
        end
    end

    vip_sync_delay #(
        .DEPTH (VIP_CSC_LAT),
        .WIDTH (3)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({per_img_vsync, per_img_href, data_en_i}),
        .dout  (sync_s)
    );

    assign post_img_vsync = sync_s[2];
    assign post_img_href  = sync_s[1];
    assign data_en_o      = sync_s[0];

    // Blanking gate on the delayed href keeps flushed blanking data off the bus.
    assign post_img_red   = post_img_href ? red_r   : 8'd0;
    assign post_img_green = post_img_href ? green_r : 8'd0;
    assign post_img_blue  = post_img_href ? blue_r  : 8'd0;

endmodule

// File: tb/tb_vip_ycbcr444_rgb888.sv
// Scoreboard bench for vip_ycbcr444_rgb888: a rounding and a truncating
// instance share stimulus; expected pixels are queued and checked at output.
module tb_vip_ycbcr444_rgb888;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs_i = 1'b0, hr_i = 1'b0, de_i = 1'b0;
    logic [7:0] y_i = 8'd0, cb_i = 8'd0, cr_i = 8'd0;
    logic       vs1, hr1, de1, vs0, hr0, de0;
    logic [7:0] r1, g1, b1, r0, g0, b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic       v, h, d;
        logic [7:0] r1, g1, b1, r0, g0, b0;
    } exp_t;
    exp_t sb_q[$];

    vip_ycbcr444_rgb888 #(.ROUND_EN(1'b1)) u_dut_rnd (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vs_i), .per_img_href(hr_i), .data_en_i(de_i),
        .per_img_Y(y_i), .per_img_Cb(cb_i), .per_img_Cr(cr_i),
        .post_img_vsync(vs1), .post_img_href(hr1), .data_en_o(de1),
        .post_img_red(r1), .post_img_green(g1), .post_img_blue(b1)
    );

    vip_ycbcr444_rgb888 #(.ROUND_EN(1'b0)) u_dut_trn (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vs_i), .per_img_href(hr_i), .data_en_i(de_i),
        .per_img_Y(y_i), .per_img_Cb(cb_i), .per_img_Cr(cr_i),
        .post_img_vsync(vs0), .post_img_href(hr0), .data_en_o(de0),
        .post_img_red(r0), .post_img_green(g0), .post_img_blue(b0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sat(input int s);
        if (s < 0) return 8'd0;
        if ((s >>> 8) > 255) return 8'd255;
        return 8'(s >>> 8);
    endfunction

    // Reference: integer BT.601 Q8 equations, floor division via arithmetic shift.
    task automatic model(input logic [7:0] y, cb, cr, input int rnd,
                         output logic [7:0] r, g, b);
        int yy, cbs, crs;
        yy  = int'(y) * 256;
        cbs = int'(cb) - 128;
        crs = int'(cr) - 128;
        r = sat(yy + 359 * crs + rnd);
        g = sat(yy - 88 * cbs - 183 * crs + rnd);
        b = sat(yy + 454 * cbs + rnd);
    endtask

    // One pixel per call; hand values (when given) override the rounding model.
    task automatic drive(input logic v, h, d, input logic [7:0] y, cb, cr,
                         input logic hand, input logic [7:0] hr, hg, hb);
        exp_t e;
        logic [7:0] mr, mg, mb;
        @(posedge clk);
        #1;
        vs_i = v; hr_i = h; de_i = d; y_i = y; cb_i = cb; cr_i = cr;
        e.due = cyc + 4;
        e.v = v; e.h = h; e.d = d;
        model(y, cb, cr, 128, mr, mg, mb);
        if (hand) begin
            mr = hr; mg = hg; mb = hb;
        end
        e.r1 = h ? mr : 8'd0; e.g1 = h ? mg : 8'd0; e.b1 = h ? mb : 8'd0;
        model(y, cb, cr, 0, mr, mg, mb);
        e.r0 = h ? mr : 8'd0; e.g0 = h ? mg : 8'd0; e.b0 = h ? mb : 8'd0;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vsync"}, int'(vs1), 0);
        check({tag, "_href"},  int'(hr1), 0);
        check({tag, "_de"},    int'(de1), 0);
        check({tag, "_rgb"},   int'({r1, g1, b1}), 0);
        check({tag, "_rgb_trunc"}, int'({r0, g0, b0, vs0, hr0, de0}), 0);
    endtask

    // Monitor: pop the entry due this cycle and compare both instances.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                e = sb_q.pop_front();
                check("stale_entry", cyc, e.due);
            end
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                check("vsync", int'(vs1), int'(e.v));
                check("href",  int'(hr1), int'(e.h));
                check("de",    int'(de1), int'(e.d));
                check("red",   int'(r1),  int'(e.r1));
                check("green", int'(g1),  int'(e.g1));
                check("blue",  int'(b1),  int'(e.b1));
                check("red_trunc",   int'(r0), int'(e.r0));
                check("green_trunc", int'(g0), int'(e.g0));
                check("blue_trunc",  int'(b0), int'(e.b0));
                check("sync_trunc",  int'({vs0, hr0, de0}), int'({e.v, e.h, e.d}));
            end
        end
    end

    initial begin
        logic h;
        #3;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Neutral greys and saturation corners with hand-computed results.
        drive(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128, 1'b1, 8'd128, 8'd128, 8'd128);
        drive(1'b0, 1'b1, 1'b1, 8'd0,   8'd128, 8'd128, 1'b1, 8'd0,   8'd0,   8'd0);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd128, 8'd128, 1'b1, 8'd255, 8'd255, 8'd255);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd128, 8'd255, 1'b1, 8'd255, 8'd164, 8'd255);
        drive(1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   8'd0,   1'b1, 8'd0,   8'd136, 8'd0);
        drive(1'b0, 1'b1, 1'b1, 8'd76,  8'd85,  8'd255, 1'b1, 8'd254, 8'd0,   8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd200, 8'd90,  8'd30,  1'b1, 8'd0,   8'd0,   8'd0);

        // Sync alignment: vsync pulse, 3-cycle href burst, offset data_en.
        drive(1'b1, 1'b0, 1'b0, 8'd50,  8'd60,  8'd70,  1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd51,  8'd61,  8'd71,  1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd100, 8'd200, 8'd40,  1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b1, 1'b1, 8'd30,  8'd10,  8'd250, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b1, 1'b1, 8'd220, 8'd140, 8'd110, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b1, 8'd90,  8'd90,  8'd90,  1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255, 1'b0, 8'd0, 8'd0, 8'd0);

        // Streaming with random href.
        for (int i = 0; i < 1024; i++) begin
            h = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 15) == 0), h, h,
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'b0, 8'd0, 8'd0, 8'd0);
        end

        // Reset in the middle of an active burst.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(60 + 20 * i), 8'd100, 8'd180,
                  1'b0, 8'd0, 8'd0, 8'd0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("held_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'd240, 8'd20, 8'd230, 1'b0, 8'd0, 8'd0, 8'd0);
        end
        drive(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128, 1'b1, 8'd128, 8'd128, 8'd128);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0);
        end

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vip_ycbcr444_rgb888.md
Name: vip_ycbcr444_rgb888

Overview:
Pipelined YCbCr444 to RGB888 colour-space converter for the VIP video chain. It is the inverse stage for the RGB-to-YCbCr front end. It takes Y/Cb/Cr pixels after luma/chroma processing (filtering, skin detect, overlay) and rebuilds RGB888 for the HDMI/LCD output path. Frame sync, line sync and data-enable are delayed in lockstep with the pixel data.

Parameters:
ROUND_EN, 1, 1 = add 0.5 LSB (+128 in Q8) before the final >>8; 0 = truncate.

Ports:
clk  input  1  pixel clock
rst_n  input  1  reset
per_img_vsync  input  1  input frame sync
per_img_href  input  1  input line valid
data_en_i  input  1  input data enable
per_img_Y  input  8  luma, 0..255
per_img_Cb  input  8  blue-difference chroma, offset 128
per_img_Cr  input  8  red-difference chroma, offset 128
post_img_vsync  output  1  per_img_vsync delayed 4 clk
post_img_href  output  1  per_img_href delayed 4 clk
data_en_o  output  1  data_en_i delayed 4 clk
post_img_red  output  8  R, 0 when post_img_href=0
post_img_green  output  8  G, 0 when post_img_href=0
post_img_blue  output  8  B, 0 when post_img_href=0

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset state: all pipeline and sync registers are 0, so every output is 0 during and after reset until new data propagates.
- Math, full-range BT.601, Q8 coefficients:
  R = Y + 359*(Cr-128)/256
  G = Y - 88*(Cb-128)/256 - 183*(Cr-128)/256
  B = Y + 454*(Cb-128)/256
- Stage 1: cb_s = Cb-128 and cr_s = Cr-128, 9-bit signed; Y registered.
- Stage 2: register four products (359*cr_s, 88*cb_s, 183*cr_s, 454*cb_s), 18-bit signed; register Y<<8.
- Stage 3: 20-bit signed sums, each = Y<<8 ± the products per the equations, + (ROUND_EN ? 128 : 0).
- Stage 4: clamp each sum. Negative gives 0; sum>>8 > 255 gives 255; otherwise sum[15:8].
- Latency is exactly 4 clk, input pixel to output pixel. Throughput is 1 pixel/clk, with no stalls and no backpressure.
- Sync pipes: 4-bit shift registers for vsync, href and data_en. Outputs are taken from bit 3.
- Output gating: RGB is forced to 0 when post_img_href=0; this is combinational on the delayed href.
- The data path runs on every clk regardless of href/data_en. Blanking data flushes through and is masked by the gating.
- Back-to-back lines, or href toggling every cycle: each pixel stays tied to its own delayed href bit, with no cross-pixel contamination.
- Reset mid-line: outputs drop to 0 asynchronously. The first valid output appears 4 clk after the first href=1 following reset release.
- Arithmetic must be signed throughout stages 1-3. No intermediate truncation is allowed before the clamp.

Decomposition:
- Shared package vip_pkg holds:
  - the Q8 coefficient constants (COEF_CR_R=359, COEF_CB_G=88, COEF_CR_G=183, COEF_CB_B=454);
  - CHROMA_OFS=128 and VIP_CSC_LAT=4, also used by the RGB-to-YCbCr stage's latency documentation.
- One natural sub-module: vip_sync_delay (parameter DEPTH). It is a reset-able shift register for vsync/href/data_en and is reusable across VIP stages.
- Clamp is inline logic, not a separate module.

Test Plan:
- Grey: Y=128, Cb=128, Cr=128 with href=1 -> RGB=(128,128,128) exactly 4 clk later. Y=0/255 with neutral chroma -> (0,0,0)/(255,255,255).
- Saturation: Y=255, Cb=128, Cr=255, ROUND_EN=1 -> R=255 (clamped high), G=164, B=255. Y=0, Cb=0, Cr=0 -> R=0 (clamped low), G=136, B=0.
- Red primary: Y=76, Cb=85, Cr=255 -> (254,0,0). With ROUND_EN=0, results match floor((sum)) on the same vectors, checked against a reference model.
- Sync alignment: a single-cycle vsync pulse, a 3-cycle href burst and an offset data_en pattern -> each appears unchanged 4 clk later. RGB is nonzero only during delayed href; blanking-period inputs give RGB=0.
- Streaming: 1024 random pixels with href toggling randomly -> every output equals the bit-exact model result (0 where href=0), with no drops or duplicates.
- Reset mid-line: assert rst_n=0 during an active href burst -> all outputs are 0 within the same cycle. After release, outputs stay 0 until 4 clk after the next href=1.
